// File: rtl/iob_uart_bridge.sv
// UART byte-stream to IOb master bridge: decodes W/R command frames and replies with ACK, NAK or read data.
// Optional inter-byte frame timeout is compiled in with `define IOB_UART_BRIDGE_TIMEOUT_EN.
module iob_uart_bridge #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int TIMEOUT_W = 16
) (
  input  logic                  clk_i,
  input  logic                  arst_n_i,
  input  logic                  cke_i,
  input  logic [7:0]            rx_data_i,
  input  logic                  rx_valid_i,
  output logic                  rx_ready_o,
  output logic [7:0]            tx_data_o,
  output logic                  tx_valid_o,
  input  logic                  tx_ready_i,
  output logic                  iob_avalid_o,
  output logic [ADDR_W-1:0]     iob_addr_o,
  output logic [DATA_W-1:0]     iob_wdata_o,
  output logic [DATA_W/8-1:0]   iob_wstrb_o,
  input  logic                  iob_rvalid_i,
  input  logic [DATA_W-1:0]     iob_rdata_i,
  input  logic                  iob_ready_i,
  output logic                  busy_o
);

  localparam int NA    = ADDR_W / 8;
  localparam int ND    = DATA_W / 8;
  localparam int CNT_W = 4;
  localparam logic [7:0] OP_W = 8'h57;
  localparam logic [7:0] OP_R = 8'h52;
  localparam logic [7:0] ACK  = 8'h06;
  localparam logic [7:0] NAK  = 8'h15;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    GET_ADDR = 3'd1,
    GET_DATA = 3'd2,
    REQ      = 3'd3,
    WAIT_RD  = 3'd4,
    SEND     = 3'd5
  } state_t;

  state_t              state_r, state_nx_s;
  logic [CNT_W-1:0]    cnt_r, cnt_nx_s;
  logic [CNT_W-1:0]    tx_last_r, tx_last_nx_s;
  logic                is_wr_r, is_wr_nx_s;
  logic [ADDR_W-1:0]   addr_r, addr_nx_s;
  logic [DATA_W-1:0]   wdata_r, wdata_nx_s;
  logic [DATA_W-1:0]   txbuf_r, txbuf_nx_s;
  logic                rx_ready_r, tx_valid_r, avalid_r, busy_r;
  logic [DATA_W/8-1:0] wstrb_r;
  logic                rx_fire_s, tx_fire_s, to_hit_s;

  assign rx_fire_s = rx_valid_i & rx_ready_r;
  assign tx_fire_s = tx_valid_r & tx_ready_i;

`ifdef IOB_UART_BRIDGE_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] to_cnt_r;

  // Inter-byte idle counter, only live while a frame is being collected
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      to_cnt_r <= {TIMEOUT_W{1'b0}};
    end else if (cke_i) begin
      if ((state_r == GET_ADDR || state_r == GET_DATA) && !rx_fire_s) begin
        to_cnt_r <= to_cnt_r + {{(TIMEOUT_W-1){1'b0}}, 1'b1};
      end else begin
        to_cnt_r <= {TIMEOUT_W{1'b0}};
      end
    end
  end

  assign to_hit_s = (state_r == GET_ADDR || state_r == GET_DATA) && (&to_cnt_r);
`else
  assign to_hit_s = 1'b0 & (TIMEOUT_W < 1);
`endif

  // Next-state, field shifting and reply loading
  always_comb begin
    state_nx_s   = state_r;
    cnt_nx_s     = cnt_r;
    tx_last_nx_s = tx_last_r;
    is_wr_nx_s   = is_wr_r;
    addr_nx_s    = addr_r;
    wdata_nx_s   = wdata_r;
    txbuf_nx_s   = txbuf_r;
    case (state_r)
      IDLE: begin
        if (rx_fire_s) begin
          cnt_nx_s = {CNT_W{1'b0}};
          if (rx_data_i == OP_W || rx_data_i == OP_R) begin
            is_wr_nx_s = (rx_data_i == OP_W);
            state_nx_s = GET_ADDR;
          end else begin
            txbuf_nx_s   = DATA_W'(NAK);
            tx_last_nx_s = {CNT_W{1'b0}};
            state_nx_s   = SEND;
          end
        end else begin
          state_nx_s = IDLE;
        end
      end
      GET_ADDR: begin
        if (rx_fire_s) begin
          // little-endian: each new byte enters at the top and earlier bytes slide down
          addr_nx_s = ADDR_W'({rx_data_i, addr_r} >> 8);
          if (cnt_r == CNT_W'(NA - 1)) begin
            cnt_nx_s   = {CNT_W{1'b0}};
            state_nx_s = is_wr_r ? GET_DATA : REQ;
          end else begin
            cnt_nx_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end else if (to_hit_s) begin
          cnt_nx_s     = {CNT_W{1'b0}};
          txbuf_nx_s   = DATA_W'(NAK);
          tx_last_nx_s = {CNT_W{1'b0}};
          state_nx_s   = SEND;
        end else begin
          state_nx_s = GET_ADDR;
        end
      end
      GET_DATA: begin
        if (rx_fire_s) begin
          wdata_nx_s = DATA_W'({rx_data_i, wdata_r} >> 8);
          if (cnt_r == CNT_W'(ND - 1)) begin
            cnt_nx_s   = {CNT_W{1'b0}};
            state_nx_s = REQ;
          end else begin
            cnt_nx_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end else if (to_hit_s) begin
          cnt_nx_s     = {CNT_W{1'b0}};
          txbuf_nx_s   = DATA_W'(NAK);
          tx_last_nx_s = {CNT_W{1'b0}};
          state_nx_s   = SEND;
        end else begin
          state_nx_s = GET_DATA;
        end
      end
      REQ: begin
        if (iob_ready_i) begin
          cnt_nx_s = {CNT_W{1'b0}};
          if (is_wr_r) begin
            txbuf_nx_s   = DATA_W'(ACK);
            tx_last_nx_s = {CNT_W{1'b0}};
            state_nx_s   = SEND;
          end else if (iob_rvalid_i) begin
            txbuf_nx_s   = iob_rdata_i;
            tx_last_nx_s = CNT_W'(ND - 1);
            state_nx_s   = SEND;
          end else begin
            state_nx_s = WAIT_RD;
          end
        end else begin
          state_nx_s = REQ;
        end
      end
      WAIT_RD: begin
        if (iob_rvalid_i) begin
          txbuf_nx_s   = iob_rdata_i;
          tx_last_nx_s = CNT_W'(ND - 1);
          cnt_nx_s     = {CNT_W{1'b0}};
          state_nx_s   = SEND;
        end else begin
          state_nx_s = WAIT_RD;
        end
      end
      SEND: begin
        if (tx_fire_s) begin
          txbuf_nx_s = txbuf_r >> 8;
          if (cnt_r == tx_last_r) begin
            cnt_nx_s   = {CNT_W{1'b0}};
            state_nx_s = IDLE;
          end else begin
            cnt_nx_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end else begin
          state_nx_s = SEND;
        end
      end
      default: begin
        state_nx_s = IDLE;
        cnt_nx_s   = {CNT_W{1'b0}};
      end
    endcase
  end

  // State, datapath and registered outputs; outputs are decoded from the next state
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_r    <= IDLE;
      cnt_r      <= {CNT_W{1'b0}};
      tx_last_r  <= {CNT_W{1'b0}};
      is_wr_r    <= 1'b0;
      addr_r     <= {ADDR_W{1'b0}};
      wdata_r    <= {DATA_W{1'b0}};
      txbuf_r    <= {DATA_W{1'b0}};
      rx_ready_r <= 1'b1;
      tx_valid_r <= 1'b0;
      avalid_r   <= 1'b0;
      busy_r     <= 1'b0;
      wstrb_r    <= {(DATA_W/8){1'b0}};
    end else if (cke_i) begin
      state_r    <= state_nx_s;
      cnt_r      <= cnt_nx_s;
      tx_last_r  <= tx_last_nx_s;
      is_wr_r    <= is_wr_nx_s;
      addr_r     <= addr_nx_s;
      wdata_r    <= wdata_nx_s;
      txbuf_r    <= txbuf_nx_s;
      rx_ready_r <= (state_nx_s == IDLE) || (state_nx_s == GET_ADDR) || (state_nx_s == GET_DATA);
      tx_valid_r <= (state_nx_s == SEND);
      avalid_r   <= (state_nx_s == REQ);
      busy_r     <= (state_nx_s != IDLE);
      wstrb_r    <= ((state_nx_s == REQ) && is_wr_nx_s) ? {(DATA_W/8){1'b1}} : {(DATA_W/8){1'b0}};
    end
  end

  assign rx_ready_o   = rx_ready_r;
  assign tx_valid_o   = tx_valid_r;
  assign tx_data_o    = txbuf_r[7:0];
  assign iob_avalid_o = avalid_r;
  assign iob_addr_o   = addr_r;
  assign iob_wdata_o  = wdata_r;
  assign iob_wstrb_o  = wstrb_r;
  assign busy_o       = busy_r;

endmodule

// File: tb/tb_iob_uart_bridge.sv
// Directed bench for iob_uart_bridge (ADDR_W=DATA_W=32): frame table plus stall, reset and timeout sequences.
module tb_iob_uart_bridge;

  logic        clk = 1'b0;
  logic        arst_n_i, cke_i;
  logic [7:0]  rx_data_i;
  logic        rx_valid_i, rx_ready_o;
  logic [7:0]  tx_data_o;
  logic        tx_valid_o, tx_ready_i;
  logic        iob_avalid_o;
  logic [31:0] iob_addr_o, iob_wdata_o, iob_rdata_i;
  logic [3:0]  iob_wstrb_o;
  logic        iob_rvalid_i, iob_ready_i, busy_o;

  iob_uart_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_W(4)) dut (
    .clk_i(clk), .arst_n_i(arst_n_i), .cke_i(cke_i),
    .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i), .rx_ready_o(rx_ready_o),
    .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i),
    .iob_avalid_o(iob_avalid_o), .iob_addr_o(iob_addr_o), .iob_wdata_o(iob_wdata_o),
    .iob_wstrb_o(iob_wstrb_o), .iob_rvalid_i(iob_rvalid_i), .iob_rdata_i(iob_rdata_i),
    .iob_ready_i(iob_ready_i), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // slave model knobs and observed traffic
  int          slv_lat = 0;
  int          slv_gap = 1;
  logic [31:0] slv_rdata = 32'h0;
  int          req_cnt = 0;
  int          av_cyc = 0;
  int          lat_err = 0;
  logic        pend_txv = 1'b0;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wstrb;
  logic [7:0]  txq[$];
  logic        slv_rd;

  typedef struct {
    logic [7:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    int          gap;
    logic [31:0] rdata;
    int          exp_req;
    logic [3:0]  exp_wstrb;
    int          exp_ntx;
    logic [31:0] exp_tx;
  } vec_t;

  localparam int NV = 7;
  vec_t vecs[NV];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // IOb slave: ready after slv_lat cycles, read data slv_gap cycles after accept (0 = same cycle)
  initial begin
    iob_ready_i = 1'b0; iob_rvalid_i = 1'b0; iob_rdata_i = 32'h0;
    forever begin
      @(negedge clk);
      if (iob_avalid_o) begin
        repeat (slv_lat) @(negedge clk);
        slv_rd = (iob_wstrb_o == 4'h0);
        iob_ready_i = 1'b1;
        if (slv_rd && slv_gap == 0) begin
          iob_rvalid_i = 1'b1; iob_rdata_i = slv_rdata;
        end
        @(negedge clk);
        iob_ready_i = 1'b0; iob_rvalid_i = 1'b0; iob_rdata_i = 32'h0;
        if (slv_rd && slv_gap > 0) begin
          repeat (slv_gap - 1) @(negedge clk);
          iob_rvalid_i = 1'b1; iob_rdata_i = slv_rdata;
          @(negedge clk);
          iob_rvalid_i = 1'b0; iob_rdata_i = 32'h0;
        end
      end
    end
  end

  always @(posedge clk) begin
    if (iob_avalid_o) av_cyc++;
    if (iob_avalid_o && iob_ready_i) begin
      req_cnt++;
      req_addr  = iob_addr_o;
      req_wdata = iob_wdata_o;
      req_wstrb = iob_wstrb_o;
    end
    if (tx_valid_o && tx_ready_i) txq.push_back(tx_data_o);
    pend_txv = (iob_avalid_o && iob_ready_i && (iob_wstrb_o != 4'h0 || iob_rvalid_i))
            || (iob_rvalid_i && !iob_avalid_o);
  end

  always @(negedge clk) begin
    if (pend_txv && !tx_valid_o) lat_err++;
  end

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    rx_data_i = b; rx_valid_i = 1'b1;
    while (!rx_ready_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!rx_ready_o) begin
      n_chk++; n_err++;
      $display("FAIL rx_accept: byte %0h not accepted within 200 cycles", b);
    end
    @(posedge clk);
    #1;
    rx_valid_i = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] wdata);
    send_byte(op);
    if (op == 8'h57 || op == 8'h52) begin
      for (int b = 0; b < 4; b++) send_byte(addr[8*b +: 8]);
    end
    if (op == 8'h57) begin
      for (int b = 0; b < 4; b++) send_byte(wdata[8*b +: 8]);
    end
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    @(negedge clk);
    while (busy_o && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk(nm, busy_o, 1'b0);
  endtask

  function automatic logic [31:0] tx_packed();
    logic [31:0] v = 32'h0;
    for (int i = 0; i < txq.size() && i < 4; i++) v[8*i +: 8] = txq[i];
    return v;
  endfunction

  initial begin
    logic [7:0] held;
    int r0, av0, bad, n;

    vecs[0] = '{8'h57, 32'h8000_0010, 32'hDEAD_BEEF, 0, 1, 32'h0,         1, 4'hF, 1, 32'h0000_0006};
    vecs[1] = '{8'h52, 32'h8000_0004, 32'h0,         3, 1, 32'h1234_5678, 1, 4'h0, 4, 32'h1234_5678};
    vecs[2] = '{8'h41, 32'h0,         32'h0,         0, 1, 32'h0,         0, 4'h0, 1, 32'h0000_0015};
    vecs[3] = '{8'h57, 32'h0000_0000, 32'hFFFF_FFFF, 2, 1, 32'h0,         1, 4'hF, 1, 32'h0000_0006};
    vecs[4] = '{8'h52, 32'hFFFF_FFFC, 32'h0,         0, 0, 32'hA5A5_0F0F, 1, 4'h0, 4, 32'hA5A5_0F0F};
    vecs[5] = '{8'h52, 32'h0000_0100, 32'h0,         1, 4, 32'h0000_0001, 1, 4'h0, 4, 32'h0000_0001};
    vecs[6] = '{8'h00, 32'h0,         32'h0,         0, 1, 32'h0,         0, 4'h0, 1, 32'h0000_0015};

    arst_n_i = 1'b0; cke_i = 1'b1; rx_valid_i = 1'b0; rx_data_i = 8'h0; tx_ready_i = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_rx_ready", rx_ready_o, 1'b1);
    chk("rst_tx_valid", tx_valid_o, 1'b0);
    chk("rst_tx_data", tx_data_o, 8'h0);
    chk("rst_avalid", iob_avalid_o, 1'b0);
    chk("rst_addr", iob_addr_o, 32'h0);
    chk("rst_wdata", iob_wdata_o, 32'h0);
    chk("rst_wstrb", iob_wstrb_o, 4'h0);
    chk("rst_busy", busy_o, 1'b0);
    arst_n_i = 1'b1;

    for (int i = 0; i < NV; i++) begin
      slv_lat = vecs[i].lat; slv_gap = vecs[i].gap; slv_rdata = vecs[i].rdata;
      r0 = req_cnt; av0 = av_cyc; txq.delete();
      send_frame(vecs[i].op, vecs[i].addr, vecs[i].wdata);
      if (vecs[i].exp_req != 0) chk($sformatf("v%0d_avalid_lat", i), iob_avalid_o, 1'b1);
      wait_idle($sformatf("v%0d_idle", i));
      chk($sformatf("v%0d_req_cnt", i), req_cnt - r0, vecs[i].exp_req);
      if (vecs[i].exp_req != 0) begin
        chk($sformatf("v%0d_addr", i), req_addr, vecs[i].addr);
        chk($sformatf("v%0d_wstrb", i), req_wstrb, vecs[i].exp_wstrb);
        if (vecs[i].exp_wstrb != 4'h0) chk($sformatf("v%0d_wdata", i), req_wdata, vecs[i].wdata);
      end else begin
        chk($sformatf("v%0d_no_avalid", i), av_cyc - av0, 0);
      end
      chk($sformatf("v%0d_tx_cnt", i), txq.size(), vecs[i].exp_ntx);
      chk($sformatf("v%0d_tx_bytes", i), tx_packed(), vecs[i].exp_tx);
      chk($sformatf("v%0d_rx_ready", i), rx_ready_o, 1'b1);
    end
    chk("reply_latency", lat_err, 0);

    // read reply with the transmitter stalled after the first byte
    slv_lat = 0; slv_gap = 1; slv_rdata = 32'hCAFE_F00D; txq.delete();
    send_frame(8'h52, 32'h0000_0040, 32'h0);
    n = 0;
    @(negedge clk);
    while (!tx_valid_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("stall_txv", tx_valid_o, 1'b1);
    @(posedge clk);
    #1;
    tx_ready_i = 1'b0;
    held = tx_data_o;
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (!tx_valid_o || tx_data_o !== held) bad++;
    end
    chk("stall_hold", bad, 0);
    chk("stall_byte", held, 8'hF0);
    @(negedge clk);
    tx_ready_i = 1'b1;
    wait_idle("stall_idle");
    chk("stall_tx_cnt", txq.size(), 4);
    chk("stall_tx_bytes", tx_packed(), 32'hCAFE_F00D);

    // asynchronous reset in the middle of the data field
    r0 = req_cnt; txq.delete();
    send_byte(8'h57);
    for (int b = 0; b < 4; b++) send_byte(8'h11 + 8'(b));
    send_byte(8'hAA);
    send_byte(8'hBB);
    @(negedge clk);
    arst_n_i = 1'b0;
    #1;
    chk("mid_rst_busy", busy_o, 1'b0);
    chk("mid_rst_rx_ready", rx_ready_o, 1'b1);
    chk("mid_rst_addr", iob_addr_o, 32'h0);
    chk("mid_rst_wdata", iob_wdata_o, 32'h0);
    chk("mid_rst_avalid", iob_avalid_o, 1'b0);
    repeat (2) @(negedge clk);
    arst_n_i = 1'b1;
    send_frame(8'h57, 32'h0000_0020, 32'h0102_0304);
    wait_idle("post_rst_idle");
    chk("post_rst_req_cnt", req_cnt - r0, 1);
    chk("post_rst_addr", req_addr, 32'h0000_0020);
    chk("post_rst_wdata", req_wdata, 32'h0102_0304);
    chk("post_rst_tx_bytes", tx_packed(), 32'h0000_0006);

`ifdef IOB_UART_BRIDGE_TIMEOUT_EN
    // stalled frame must time out with a NAK and no request
    r0 = req_cnt; av0 = av_cyc; txq.delete();
    send_byte(8'h52);
    send_byte(8'h04);
    wait_idle("to_idle");
    chk("to_no_req", av_cyc - av0, 0);
    chk("to_tx_cnt", txq.size(), 1);
    chk("to_tx_bytes", tx_packed(), 32'h0000_0015);
    chk("to_rx_ready", rx_ready_o, 1'b1);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
